// File: rtl/vram_scanout_if.sv
// VRAM read port and RGB888 pixel stream of the display scanout.
interface vram_scanout_if;
    logic [8:0]  vram_line;
    logic [11:0] vram_col;
    logic [3:0]  vram_mode;
    logic        vram_re;
    logic [23:0] vram_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_rgb;
    logic        pix_sol;
    logic        pix_eol;
    logic        pix_eof;

    modport master (
        output vram_line, vram_col, vram_mode, vram_re,
        input  vram_data,
        output pix_valid, pix_rgb, pix_sol, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  vram_line, vram_col, vram_mode, vram_re,
        output vram_data,
        input  pix_valid, pix_rgb, pix_sol, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/vram_scanout.sv
// Display scanout: walks a VRAM rectangle line by line, converts pixels to
// RGB888 with line/frame flags and buffers them in a FIFO for the encoder.
module vram_scanout #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk_53_2MHz,
    input  logic           rst,
    input  logic           frame_start,
    input  logic           abort,
    input  logic           disp_24bpp,
    input  logic [9:0]     disp_x0,
    input  logic [8:0]     disp_y0,
    input  logic [9:0]     disp_w,
    input  logic [8:0]     disp_h,
    vram_scanout_if.master bus,
    output logic           busy,
    output logic           frame_done
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state;

    logic          mode24;
    logic [3:0]    mode_q;
    logic [9:0]    x0_q, w_q, col_idx, col_q;
    logic [8:0]    h_q, line_idx, line_q;
    logic          zero_done;

    logic [26:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          push, pop, valid, last_col, last_line, col_wrap;
    logic [9:0]    x0_start;
    logic [23:0]   rgb;
    logic [26:0]   head;

    always_comb begin
        push      = (state == FETCH) && (count < FULL);
        valid     = count != '0;
        pop       = valid && bus.pix_ready;
        head      = mem[rd_ptr];
        last_col  = col_idx == w_q - 10'd1;
        last_line = line_idx == h_q - 9'd1;
        col_wrap  = mode24 ? (col_q == 10'd681) : (col_q == 10'd1023);
        // a 24bpp line is 682 pixels wide, so the origin is folded into range once
        x0_start  = (disp_24bpp && disp_x0 >= 10'd682) ? disp_x0 - 10'd682 : disp_x0;
        if (mode24)
            rgb = {bus.vram_data[7:0], bus.vram_data[15:8], bus.vram_data[23:16]};
        else
            rgb = {bus.vram_data[4:0],   bus.vram_data[4:2],
                   bus.vram_data[9:5],   bus.vram_data[9:7],
                   bus.vram_data[14:10], bus.vram_data[14:12]};
    end

    assign bus.vram_re   = push;
    assign bus.vram_line = line_q;
    assign bus.vram_col  = {2'b00, col_q};
    assign bus.vram_mode = mode_q;
    assign bus.pix_valid = valid;
    assign {bus.pix_eof, bus.pix_eol, bus.pix_sol, bus.pix_rgb} = valid ? head : '0;
    assign busy       = (state != IDLE) || valid;
    assign frame_done = zero_done || (pop && head[26] && (state == DRAIN));

    always_ff @(posedge clk_53_2MHz) begin
        if (rst) begin
            state     <= IDLE;
            mode24    <= 1'b0;
            mode_q    <= 4'd2;
            x0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_idx   <= '0;
            line_idx  <= '0;
            col_q     <= '0;
            line_q    <= '0;
            zero_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (abort) begin
            state     <= IDLE;
            zero_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            zero_done <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        mode24   <= disp_24bpp;
                        mode_q   <= disp_24bpp ? 4'd8 : 4'd2;
                        x0_q     <= x0_start;
                        w_q      <= disp_w;
                        h_q      <= disp_h;
                        col_q    <= x0_start;
                        line_q   <= disp_y0;
                        col_idx  <= '0;
                        line_idx <= '0;
                        if (disp_w == '0 || disp_h == '0)
                            zero_done <= 1'b1;
                        else
                            state <= FETCH;
                    end
                end
                FETCH: begin
                    if (push) begin
                        if (last_col) begin
                            col_idx  <= '0;
                            col_q    <= x0_q;
                            line_idx <= line_idx + 9'd1;
                            line_q   <= line_q + 9'd1;
                            if (last_line)
                                state <= DRAIN;
                        end else begin
                            col_idx <= col_idx + 10'd1;
                            col_q   <= col_wrap ? '0 : col_q + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head[26])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_53_2MHz) begin
        if (push)
            mem[wr_ptr] <= {last_col && last_line, last_col, col_idx == '0, rgb};
    end
endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: a frame-level model predicts every read address,
// pixel, flag and handshake per cycle; directed frames pin the model.
module tb_vram_scanout;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, frame_start, abort, disp_24bpp;
    logic [9:0] disp_x0, disp_w;
    logic [8:0] disp_y0, disp_h;
    logic       busy, frame_done;

    vram_scanout_if bus();

    vram_scanout #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_53_2MHz(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
        .disp_24bpp(disp_24bpp), .disp_x0(disp_x0), .disp_y0(disp_y0),
        .disp_w(disp_w), .disp_h(disp_h), .bus(bus), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0, errors = 0;
    bit          fixed_en = 1'b0;
    logic [23:0] fixed_val = '0;
    logic [31:0] seed = 32'h1234_5678;
    int          ready_mode = 0;

    bit          m_ok = 1'b0, m_active = 1'b0, m_zero = 1'b0, m_b24 = 1'b0;
    int unsigned m_x0, m_y0, m_w, m_h, m_total, m_reads = 0, m_accepts = 0;
    logic [3:0]  m_mode = 4'd2;

    int unsigned rd_col_q[$], rd_line_q[$], rd_mode_q[$], acc_rgb_q[$], acc_flag_q[$];
    int unsigned done_cnt = 0, done_acc = 0, cyc = 0;
    int          fs_cyc = -1, re1_cyc = -1, v1_cyc = -1;

    function automatic logic [23:0] vram_fn(input logic [8:0] ln, input logic [11:0] cl,
                                            input bit fen, input logic [23:0] fv,
                                            input logic [31:0] sd);
        logic [31:0] h;
        h = ({23'd0, ln} * 32'h9E37_79B1) ^ ({20'd0, cl} * 32'h0000_9E37) ^ sd;
        return fen ? fv : h[26:3];
    endfunction

    always_comb bus.vram_data = vram_fn(bus.vram_line, bus.vram_col, fixed_en, fixed_val, seed);

    function automatic logic [23:0] conv(input bit b24, input logic [23:0] d);
        int unsigned r, g, b, v;
        if (b24) begin
            r = d % 256; g = (d / 256) % 256; b = d / 65536;
        end else begin
            v = d % 32768;
            r = v % 32; g = (v / 32) % 32; b = (v / 1024) % 32;
            r = r * 8 + r / 4; g = g * 8 + g / 4; b = b * 8 + b / 4;
        end
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    // Pixel k of the current frame: address, converted colour and {eof,eol,sol}.
    task automatic exp_pixel(input int unsigned k, output logic [8:0] ln,
                             output logic [11:0] cl, output logic [26:0] px);
        int unsigned i, j;
        bit sol, eol, eof;
        j = k / m_w;
        i = k % m_w;
        ln = 9'((m_y0 + j) % 512);
        if (m_b24) cl = 12'(((m_x0 % 682) + i) % 682);
        else       cl = 12'((m_x0 + i) % 1024);
        sol = (i == 0);
        eol = (i == m_w - 1);
        eof = eol && (j == m_h - 1);
        px = {eof, eol, sol, conv(m_b24, vram_fn(ln, cl, fixed_en, fixed_val, seed))};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int unsigned cnt;
        bit re_exp, v_exp, acc, eofp, was_idle;
        logic [8:0]  eln;
        logic [11:0] ecl;
        logic [26:0] epx;
        cyc++;
        re_exp = 1'b0; v_exp = 1'b0; acc = 1'b0; eofp = 1'b0;
        if (m_ok) begin
            cnt    = m_reads - m_accepts;
            re_exp = m_active && (m_reads < m_total) && (cnt < DEPTH);
            v_exp  = cnt != 0;
            check("vram_re", bus.vram_re, re_exp);
            check("vram_mode", bus.vram_mode, m_mode);
            if (re_exp && bus.vram_re) begin
                exp_pixel(m_reads, eln, ecl, epx);
                check("vram_line", bus.vram_line, eln);
                check("vram_col", bus.vram_col, ecl);
            end
            check("pix_valid", bus.pix_valid, v_exp);
            if (v_exp) begin
                exp_pixel(m_accepts, eln, ecl, epx);
                if (bus.pix_valid) begin
                    check("pix_rgb", bus.pix_rgb, epx[23:0]);
                    check("pix_flags", {bus.pix_eof, bus.pix_eol, bus.pix_sol}, epx[26:24]);
                end
                acc  = bus.pix_ready;
                eofp = acc && epx[26];
            end
            check("frame_done", frame_done, m_zero || eofp);
            check("busy", busy, m_active);
        end
        if (bus.vram_re) begin
            rd_col_q.push_back(bus.vram_col);
            rd_line_q.push_back(bus.vram_line);
            rd_mode_q.push_back(bus.vram_mode);
            if (re1_cyc < 0) re1_cyc = cyc;
        end
        if (bus.pix_valid && v1_cyc < 0) v1_cyc = cyc;
        if (bus.pix_valid && bus.pix_ready) begin
            acc_rgb_q.push_back(bus.pix_rgb);
            acc_flag_q.push_back({bus.pix_eof, bus.pix_eol, bus.pix_sol});
        end
        if (frame_done) begin
            done_cnt++;
            done_acc = m_accepts + (acc ? 1 : 0);
        end

        if (rst) begin
            m_ok = 1'b1; m_active = 1'b0; m_zero = 1'b0; m_mode = 4'd2;
            m_reads = 0; m_accepts = 0;
        end else if (m_ok) begin
            was_idle = !m_active;
            m_zero = 1'b0;
            if (abort) begin
                m_active = 1'b0; m_reads = 0; m_accepts = 0;
            end else begin
                if (re_exp) m_reads++;
                if (acc) begin
                    m_accepts++;
                    if (eofp) m_active = 1'b0;
                end
                if (was_idle && frame_start) begin
                    m_b24 = disp_24bpp; m_x0 = disp_x0; m_y0 = disp_y0;
                    m_w = disp_w; m_h = disp_h;
                    m_mode = disp_24bpp ? 4'd8 : 4'd2;
                    fs_cyc = cyc; re1_cyc = -1; v1_cyc = -1;
                    if (disp_w == 0 || disp_h == 0) m_zero = 1'b1;
                    else begin
                        m_active = 1'b1; m_reads = 0; m_accepts = 0; m_total = m_w * m_h;
                    end
                end
            end
        end
    end

    initial begin
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = ($urandom_range(0, 3) != 0);
                default: bus.pix_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        tick(); tick();
    endtask

    task automatic clear_logs();
        rd_col_q.delete(); rd_line_q.delete(); rd_mode_q.delete();
        acc_rgb_q.delete(); acc_flag_q.delete();
        done_cnt = 0; done_acc = 0;
    endtask

    // Geometry is scrambled right after the pulse to show it was latched.
    task automatic start_frame(input bit b24, input int unsigned x0, y0, w, h);
        disp_24bpp = b24; disp_x0 = 10'(x0); disp_y0 = 9'(y0);
        disp_w = 10'(w); disp_h = 9'(h);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        disp_24bpp = 1'($urandom); disp_x0 = 10'($urandom); disp_y0 = 9'($urandom);
        disp_w = 10'($urandom); disp_h = 9'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (!m_active && !m_zero) return;
            tick();
        end
        vectors++; errors++;
        $display("FAIL wait_idle: frame still active after %0d cycles, required idle", budget);
    endtask

    int unsigned t1_cols [4] = '{1022, 1023, 0, 1};
    int unsigned t1_flags[8] = '{1, 0, 0, 2, 1, 0, 0, 6};
    int unsigned t3_cols [4] = '{680, 681, 0, 1};

    initial begin
        rst = 1'b1; frame_start = 1'b0; abort = 1'b0; disp_24bpp = 1'b0;
        disp_x0 = '0; disp_y0 = '0; disp_w = '0; disp_h = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_vram_re", bus.vram_re, 0);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_vram_mode", bus.vram_mode, 2);
        check("rst_frame_done", frame_done, 0);
        tick();
        rst = 1'b0;
        set_ready(0);

        // 16bpp wrap of column and line, flags, done position, latency
        clear_logs();
        start_frame(0, 1022, 511, 4, 2);
        wait_idle(100);
        check("t1_reads", rd_col_q.size(), 8);
        if (rd_col_q.size() == 8)
            for (int k = 0; k < 8; k++) begin
                check("t1_col", rd_col_q[k], t1_cols[k % 4]);
                check("t1_line", rd_line_q[k], (k < 4) ? 511 : 0);
            end
        check("t1_accepts", acc_flag_q.size(), 8);
        if (acc_flag_q.size() == 8)
            for (int k = 0; k < 8; k++) check("t1_flags", acc_flag_q[k], t1_flags[k]);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_at", done_acc, 8);
        check("t1_re_latency", 32'(re1_cyc - fs_cyc), 1);
        check("t1_valid_latency", 32'(v1_cyc - fs_cyc), 2);

        // 16bpp colour expansion
        fixed_en = 1'b1; fixed_val = 24'h007FFF;
        clear_logs();
        start_frame(0, 5, 7, 1, 1);
        wait_idle(50);
        check("t2_white", (acc_rgb_q.size() > 0) ? acc_rgb_q[0] : 32'hDEAD, 24'hFFFFFF);
        fixed_val = 24'hA5801F;
        clear_logs();
        start_frame(0, 5, 7, 1, 1);
        wait_idle(50);
        check("t2_red", (acc_rgb_q.size() > 0) ? acc_rgb_q[0] : 32'hDEAD, 24'hFF0000);

        // 24bpp column wrap at 682
        fixed_val = 24'h332211;
        clear_logs();
        start_frame(1, 680, 3, 4, 1);
        wait_idle(50);
        check("t3_reads", rd_col_q.size(), 4);
        if (rd_col_q.size() == 4)
            for (int k = 0; k < 4; k++) check("t3_col", rd_col_q[k], t3_cols[k]);
        check("t3_mode", (rd_mode_q.size() > 0) ? rd_mode_q[0] : 0, 8);
        check("t3_rgb", (acc_rgb_q.size() > 0) ? acc_rgb_q[0] : 32'hDEAD, 24'h112233);
        fixed_en = 1'b0;

        // backpressure: FIFO fills, no reads beyond depth, nothing lost
        set_ready(2);
        clear_logs();
        start_frame(0, 100, 20, 64, 1);
        repeat (40) tick();
        @(negedge clk);
        check("t4_reads_full", rd_col_q.size(), DEPTH);
        check("t4_re_stopped", bus.vram_re, 0);
        tick();
        set_ready(0);
        wait_idle(300);
        check("t4_reads", rd_col_q.size(), 64);
        check("t4_accepts", acc_rgb_q.size(), 64);
        check("t4_last_flags", (acc_flag_q.size() == 64) ? acc_flag_q[63] : 0, 6);

        // abort in line 3, then a normal frame
        clear_logs();
        start_frame(1, 3, 40, 8, 8);
        for (int n = 0; n < 200 && m_reads < 27; n++) tick();
        check("t5_reached_line3", (m_reads >= 27) ? 1 : 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t5_valid", bus.pix_valid, 0);
        check("t5_re", bus.vram_re, 0);
        check("t5_busy", busy, 0);
        repeat (5) tick();
        check("t5_no_done", done_cnt, 0);
        clear_logs();
        start_frame(0, 9, 9, 5, 3);
        wait_idle(100);
        check("t5_after_accepts", acc_rgb_q.size(), 15);
        check("t5_after_done", done_cnt, 1);

        // zero-sized frames
        clear_logs();
        start_frame(0, 0, 0, 0, 5);
        @(negedge clk);
        check("t6_w0_done", frame_done, 1);
        check("t6_w0_busy", busy, 0);
        tick();
        @(negedge clk);
        check("t6_w0_done_end", frame_done, 0);
        tick();
        start_frame(1, 0, 0, 7, 0);
        @(negedge clk);
        check("t6_h0_done", frame_done, 1);
        tick();
        check("t6_no_reads", rd_col_q.size(), 0);

        // frame_start while busy is ignored
        set_ready(1);
        clear_logs();
        start_frame(0, 50, 60, 20, 3);
        repeat (5) tick();
        disp_w = 10'd3; disp_h = 9'd1; disp_24bpp = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_idle(500);
        check("t7_accepts", acc_rgb_q.size(), 60);
        check("t7_done_cnt", done_cnt, 1);

        // synchronous reset mid-frame
        set_ready(0);
        clear_logs();
        start_frame(1, 0, 0, 10, 2);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t8_valid", bus.pix_valid, 0);
        check("t8_busy", busy, 0);
        check("t8_mode", bus.vram_mode, 2);
        tick();

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            seed = $urandom;
            set_ready(int'($urandom_range(0, 1)));
            start_frame(1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 511),
                        $urandom_range(1, 40), $urandom_range(1, 5));
            wait_idle(1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
